hero_write_rx: RTL and testbench

Receive end of the hero write bus. Consumes the `hero_write_t` beat stream from package `test_pkg_a` and stages beats in a commit-on-DONE FIFO. Presents only complete transactions to a downstream consumer over a valid/ready beat interface. The hero bus has no backpressure, so the block rolls back and drops any transaction it cannot fully hold, and flags an error.

---
 rtl/hero_write_rx.sv | 212 +++++++++++++++++++++
 tb/tb_hero_write_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hero_write_rx.sv
// hero_write_rx: receive end of the hero write bus.
// Stages hero beats in a commit-on-DONE FIFO and presents only complete
// transactions downstream over a valid/ready beat interface. Transactions
// that cannot be held in full are rolled back, dropped and flagged.
//
// Ports:
//   clk           sole clock
//   rst           synchronous active-high reset
//   hero_wr       incoming beat (cycle_type, wdat, struct_reference, clk_en)
//   out_valid     head beat available
//   out_ready     consumer accepts head beat
//   out_wdat      head beat data
//   out_sub       head beat struct_reference
//   out_last      head beat was the DONE beat
//   overflow_err  one-cycle pulse: transaction dropped
//   proto_err     one-cycle pulse: illegal cycle_type
//
// Optional feature macro: HERO_WRITE_RX_PROTO_CHECK_EN (illegal cycle_type
// detection; when undefined proto_err is tied low and undefined encodings
// are treated as IDLE).

package test_pkg_a;
  localparam int unsigned HERO_WIDTH = 32;

  // cycle_type encodings; 2'd3 is undefined
  localparam logic [1:0] CYC_IDLE  = 2'd0;
  localparam logic [1:0] CYC_VALID = 2'd1;
  localparam logic [1:0] CYC_DONE  = 2'd2;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] tag;
  } sub_struct_t;

  typedef struct packed {
    logic [1:0]            cycle_type;
    logic [HERO_WIDTH-1:0] wdat;
    sub_struct_t           struct_reference;
    logic                  clk_en;
  } hero_write_t;

  typedef struct packed {
    logic [HERO_WIDTH-1:0] wdat;
    sub_struct_t           sub;
    logic                  last;
  } hero_entry_t;
endpackage

module hero_write_rx
  import test_pkg_a::*;
#(
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned MAX_BEATS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  hero_write_t           hero_wr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [HERO_WIDTH-1:0] out_wdat,
  output sub_struct_t           out_sub,
  output logic                  out_last,
  output logic                  overflow_err,
  output logic                  proto_err
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DROP} state_t;

  state_t      r_state, w_state_nxt;
  hero_entry_t r_mem [DATA_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_start_ptr, r_commit_ptr, r_rd_ptr;
  logic [CW-1:0] r_beat_cnt, w_cnt_nxt;
  logic          r_overflow_err;

  logic          w_beat, w_done, w_full, w_rd;
  logic [PW-1:0] w_occ;
  logic          w_we, w_last, w_commit, w_rollback, w_start, w_ovf;
  hero_entry_t   w_head;

`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
  logic r_proto_err, w_illegal, w_perr;
  assign w_illegal = hero_wr.clk_en && (hero_wr.cycle_type == 2'd3);
  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

  // Beat qualification; IDLE and gated cycles never count
  assign w_beat = hero_wr.clk_en &&
                  (hero_wr.cycle_type == CYC_VALID || hero_wr.cycle_type == CYC_DONE);
  assign w_done = (hero_wr.cycle_type == CYC_DONE);
  // Space uses pre-read occupancy, including uncommitted beats
  assign w_occ  = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_occ == PW'(DATA_DEPTH));
  assign w_rd   = out_valid && out_ready;

  // Output side sees only committed data
  assign out_valid = (r_rd_ptr != r_commit_ptr);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign out_wdat  = w_head.wdat;
  assign out_sub   = w_head.sub;
  assign out_last  = w_head.last;
  assign overflow_err = r_overflow_err;

  // Next-state and write control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_we        = 1'b0;
    w_last      = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_start     = 1'b0;
    w_ovf       = 1'b0;
`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
    w_perr      = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          if (w_full) begin
            w_ovf = 1'b1;
            if (!w_done) w_state_nxt = ST_DROP;
          end else begin
            w_we = 1'b1;
            if (w_done) begin
              w_last   = 1'b1;
              w_commit = 1'b1;
            end else begin
              w_start     = 1'b1;
              w_cnt_nxt   = CW'(1);
              w_state_nxt = ST_ACCUM;
            end
          end
        end
`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
        else if (w_illegal) w_perr = 1'b1;
`endif
      end
      ST_ACCUM: begin
        if (w_beat) begin
          if (!w_full && (r_beat_cnt < CW'(MAX_BEATS))) begin
            w_we      = 1'b1;
            w_cnt_nxt = r_beat_cnt + CW'(1);
            if (w_done) begin
              w_last      = 1'b1;
              w_commit    = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_rollback  = 1'b1;
            w_ovf       = 1'b1;
            w_state_nxt = w_done ? ST_IDLE : ST_DROP;
          end
        end
`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
        else if (w_illegal) begin
          w_perr      = 1'b1;
          w_rollback  = 1'b1;
          w_state_nxt = ST_DROP;
        end
`endif
      end
      ST_DROP: begin
        if (w_beat && w_done) w_state_nxt = ST_IDLE;
`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
        else if (w_illegal) w_perr = 1'b1;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pointers and beat storage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_start_ptr    <= '0;
      r_commit_ptr   <= '0;
      r_rd_ptr       <= '0;
      r_beat_cnt     <= '0;
      r_overflow_err <= 1'b0;
`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
      r_proto_err    <= 1'b0;
`endif
      for (int unsigned i = 0; i < DATA_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat_cnt     <= w_cnt_nxt;
      r_overflow_err <= w_ovf;
`ifdef HERO_WRITE_RX_PROTO_CHECK_EN
      r_proto_err    <= w_perr;
`endif
      if (w_we) begin
        r_mem[r_wr_ptr[AW-1:0]] <= '{wdat: hero_wr.wdat,
                                     sub:  hero_wr.struct_reference,
                                     last: w_last};
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rollback) r_wr_ptr     <= r_start_ptr;
      if (w_start)    r_start_ptr  <= r_wr_ptr;
      if (w_commit)   r_commit_ptr <= r_wr_ptr + PW'(1);
      if (w_rd)       r_rd_ptr     <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_hero_write_rx.sv
// tb_hero_write_rx: directed self-checking bench for hero_write_rx
// (DATA_DEPTH=16, MAX_BEATS=8). Inputs change 1 time unit after the rising
// edge; outputs are sampled at that same offset, away from the edge.
module tb_hero_write_rx;
  import test_pkg_a::*;

  logic                  clk = 1'b0;
  logic                  rst;
  hero_write_t           hero_wr;
  logic                  out_valid;
  logic                  out_ready;
  logic [HERO_WIDTH-1:0] out_wdat;
  sub_struct_t           out_sub;
  logic                  out_last;
  logic                  overflow_err;
  logic                  proto_err;

  int total = 0;
  int bad   = 0;

  hero_write_rx #(.DATA_DEPTH(16), .MAX_BEATS(8)) dut (
    .clk(clk), .rst(rst), .hero_wr(hero_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wdat(out_wdat), .out_sub(out_sub), .out_last(out_last),
    .overflow_err(overflow_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] ct, input logic [31:0] d, input logic en);
    hero_wr.cycle_type       = ct;
    hero_wr.wdat             = d;
    hero_wr.struct_reference = sub_struct_t'(d[7:0]);
    hero_wr.clk_en           = en;
  endtask

  task automatic quiet();
    drv(CYC_IDLE, 32'd0, 1'b0);
  endtask

  // Head beat check; sub field is expected to equal the low data byte
  task automatic head(input string tag, input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".wdat"},  {32'd0, out_wdat}, {32'd0, d});
    chk({tag, ".sub"},   {56'd0, out_sub}, {56'd0, d[7:0]});
    chk({tag, ".last"},  64'(out_last), 64'(l));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".ovf"},   64'(overflow_err), 64'd0);
    chk({tag, ".perr"},  64'(proto_err), 64'd0);
    chk({tag, ".wdat"},  {32'd0, out_wdat}, 64'd0);
    chk({tag, ".sub"},   {56'd0, out_sub}, 64'd0);
    chk({tag, ".last"},  64'(out_last), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    quiet();
    step(); step();
    rst = 1'b0;
    reset_vals("reset");

    // 3-beat transaction, consumer always ready
    drv(CYC_VALID, 32'hA1, 1'b1); step();
    chk("t1.hidden_a", 64'(out_valid), 64'd0);
    drv(CYC_VALID, 32'hB2, 1'b1); step();
    chk("t1.hidden_b", 64'(out_valid), 64'd0);
    drv(CYC_DONE,  32'hC3, 1'b1); step();
    quiet();
    head("t1.a", 32'hA1, 1'b0); step();
    head("t1.b", 32'hB2, 1'b0); step();
    head("t1.c", 32'hC3, 1'b1); step();
    chk("t1.empty", 64'(out_valid), 64'd0);

    // Lone DONE beat from IDLE
    drv(CYC_DONE, 32'hD4, 1'b1); step();
    quiet();
    head("t2.d", 32'hD4, 1'b1);
    chk("t2.ovf", 64'(overflow_err), 64'd0);
    step();
    chk("t2.empty", 64'(out_valid), 64'd0);

    // Fill to 16 with two 8-beat transactions, then overflow from IDLE
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 8; i++) begin
        drv((i == 7) ? CYC_DONE : CYC_VALID, 32'h100 * (t + 1) + i, 1'b1);
        step();
      end
    end
    quiet();
    head("t3.full_head", 32'h100, 1'b0);
    chk("t3.no_ovf_yet", 64'(overflow_err), 64'd0);
    drv(CYC_VALID, 32'h300, 1'b1); step();
    chk("t3.ovf_pulse", 64'(overflow_err), 64'd1);
    drv(CYC_VALID, 32'h301, 1'b1); step();
    chk("t3.ovf_once", 64'(overflow_err), 64'd0);
    drv(CYC_DONE, 32'h302, 1'b1); step();
    chk("t3.ovf_done", 64'(overflow_err), 64'd0);
    quiet();
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 8; i++) begin
        head($sformatf("t3.rd%0d_%0d", t, i), 32'h100 * (t + 1) + i, (i == 7));
        step();
      end
    end
    chk("t3.drained", 64'(out_valid), 64'd0);

    // 9-beat transaction exceeds MAX_BEATS and is rolled back
    for (int i = 0; i < 9; i++) begin
      drv((i == 8) ? CYC_DONE : CYC_VALID, 32'h400 + i, 1'b1);
      step();
      chk($sformatf("t4.hidden%0d", i), 64'(out_valid), 64'd0);
      chk($sformatf("t4.ovf%0d", i), 64'(overflow_err), 64'(i == 8));
    end
    quiet(); step();
    chk("t4.still_empty", 64'(out_valid), 64'd0);
    chk("t4.ovf_clear", 64'(overflow_err), 64'd0);
    drv(CYC_VALID, 32'h500, 1'b1); step();
    drv(CYC_DONE,  32'h501, 1'b1); step();
    quiet();
    head("t4.next_a", 32'h500, 1'b0); step();
    head("t4.next_b", 32'h501, 1'b1); step();
    chk("t4.empty", 64'(out_valid), 64'd0);

    // Same as first transaction with gated and IDLE cycles interleaved
    drv(CYC_VALID, 32'hA1, 1'b1); step();
    drv(CYC_VALID, 32'hEE, 1'b0); step();
    drv(CYC_IDLE,  32'hEF, 1'b1); step();
    drv(CYC_VALID, 32'hB2, 1'b1); step();
    drv(CYC_DONE,  32'hF0, 1'b0); step();
    chk("t5.hidden", 64'(out_valid), 64'd0);
    drv(CYC_DONE,  32'hC3, 1'b1); step();
    quiet();
    head("t5.a", 32'hA1, 1'b0); step();
    head("t5.b", 32'hB2, 1'b0); step();
    head("t5.c", 32'hC3, 1'b1); step();
    chk("t5.empty", 64'(out_valid), 64'd0);

    // Reset mid-transaction, then a lone DONE
    drv(CYC_VALID, 32'hA1, 1'b1); step();
    drv(CYC_VALID, 32'hB2, 1'b1); step();
    quiet();
    rst = 1'b1; step();
    rst = 1'b0;
    reset_vals("t6.reset");
    step();
    chk("t6.no_partial", 64'(out_valid), 64'd0);
    drv(CYC_DONE, 32'hE5, 1'b1); step();
    quiet();
    head("t6.e", 32'hE5, 1'b1); step();
    chk("t6.empty", 64'(out_valid), 64'd0);
    chk("t6.perr", 64'(proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
